// File: rtl/telemetry_command_interpreter_pkg.sv
// Shared codes, channel map and TX state encoding for the
// telemetry command interpreter and its reply serializer.
package telemetry_interp_pkg;

  localparam int NUM_CHANNELS = 12;

  localparam logic [7:0] CODE_WP_BASE = 8'd1;
  localparam logic [7:0] CODE_STOP    = 8'd9;
  localparam logic [7:0] CODE_BEGIN   = 8'd10;
  localparam logic [7:0] CODE_X       = 8'd20;
  localparam logic [7:0] CODE_Y       = 8'd21;
  localparam logic [7:0] CODE_THETA   = 8'd22;
  localparam logic [7:0] CODE_RPM1    = 8'd30;
  localparam logic [7:0] CODE_RPM2    = 8'd31;
  localparam logic [7:0] CODE_RPM3    = 8'd32;
  localparam logic [7:0] CODE_RPM4    = 8'd33;
  localparam logic [7:0] CODE_DIST1   = 8'd40;
  localparam logic [7:0] CODE_DIST2   = 8'd41;
  localparam logic [7:0] CODE_DIST3   = 8'd42;
  localparam logic [7:0] CODE_DIST4   = 8'd43;
  localparam logic [7:0] CODE_BEHAV   = 8'd50;

  localparam logic [3:0] CH_X     = 4'd0;
  localparam logic [3:0] CH_Y     = 4'd1;
  localparam logic [3:0] CH_THETA = 4'd2;
  localparam logic [3:0] CH_RPM1  = 4'd3;
  localparam logic [3:0] CH_RPM2  = 4'd4;
  localparam logic [3:0] CH_RPM3  = 4'd5;
  localparam logic [3:0] CH_RPM4  = 4'd6;
  localparam logic [3:0] CH_DIST1 = 4'd7;
  localparam logic [3:0] CH_DIST2 = 4'd8;
  localparam logic [3:0] CH_DIST3 = 4'd9;
  localparam logic [3:0] CH_DIST4 = 4'd10;
  localparam logic [3:0] CH_BEHAV = 4'd11;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_HEADER  = 2'd1,
    TX_PAYLOAD = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } chan_sel_t;

  function automatic chan_sel_t code_to_channel(
    input logic [7:0] code
  );
    chan_sel_t r;
    r = '{hit: 1'b1, idx: 4'd0};
    case (code)
      CODE_X:     r.idx = CH_X;
      CODE_Y:     r.idx = CH_Y;
      CODE_THETA: r.idx = CH_THETA;
      CODE_RPM1:  r.idx = CH_RPM1;
      CODE_RPM2:  r.idx = CH_RPM2;
      CODE_RPM3:  r.idx = CH_RPM3;
      CODE_RPM4:  r.idx = CH_RPM4;
      CODE_DIST1: r.idx = CH_DIST1;
      CODE_DIST2: r.idx = CH_DIST2;
      CODE_DIST3: r.idx = CH_DIST3;
      CODE_DIST4: r.idx = CH_DIST4;
      CODE_BEHAV: r.idx = CH_BEHAV;
      default:    r.hit = 1'b0;
    endcase
    return r;
  endfunction

  // rpm and behaviour carry only a byte-wide value
  function automatic logic is_narrow(
    input logic [3:0] idx
  );
    return (idx >= CH_RPM1 && idx <= CH_RPM4) ||
           (idx == CH_BEHAV);
  endfunction

endpackage

// File: rtl/telemetry_command_interpreter_tx_response_serializer.sv
// Reply serializer: header + MSB-first payload under valid/ready,
// with a 1-deep pending slot. Ports: req_*_i in, tx_*_o out, drop_o.
module tx_response_serializer
  import telemetry_interp_pkg::*;
#(
  parameter int N_WIDTH        = 17,
  parameter int INT_WIDTH      = 8,
  parameter int BYTES_PER_WORD = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic [INT_WIDTH-1:0] req_code_i,
  input  logic [N_WIDTH-1:0]   req_word_i,
  input  logic                 tx_ready_i,
  output logic                 tx_valid_o,
  output logic [INT_WIDTH-1:0] tx_data_o,
  output logic                 drop_o
);

  localparam int PW = BYTES_PER_WORD * INT_WIDTH;
  localparam int IW = (BYTES_PER_WORD > 1) ?
                      $clog2(BYTES_PER_WORD) : 1;

  tx_state_e            state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [INT_WIDTH-1:0] cur_code_q, cur_code_d;
  logic [PW-1:0]        cur_word_q, cur_word_d;
  logic                 pend_v_q, pend_v_d;
  logic [INT_WIDTH-1:0] pend_code_q, pend_code_d;
  logic [PW-1:0]        pend_word_q, pend_word_d;

  logic [PW-1:0] req_word;
  logic          last;

  assign req_word = PW'(req_word_i);

  // final payload byte leaves on this edge
  assign last = (state_q == TX_PAYLOAD) &&
                (idx_q == '0) && tx_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= TX_IDLE;
      idx_q       <= '0;
      cur_code_q  <= '0;
      cur_word_q  <= '0;
      pend_v_q    <= 1'b0;
      pend_code_q <= '0;
      pend_word_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_code_q  <= cur_code_d;
      cur_word_q  <= cur_word_d;
      pend_v_q    <= pend_v_d;
      pend_code_q <= pend_code_d;
      pend_word_q <= pend_word_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_code_d  = cur_code_q;
    cur_word_d  = cur_word_q;
    pend_v_d    = pend_v_q;
    pend_code_d = pend_code_q;
    pend_word_d = pend_word_q;
    drop_o      = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        if (req_valid_i) begin
          cur_code_d = req_code_i;
          cur_word_d = req_word;
          state_d    = TX_HEADER;
        end
      end
      TX_HEADER: begin
        if (tx_ready_i) begin
          state_d = TX_PAYLOAD;
          idx_d   = IW'(BYTES_PER_WORD - 1);
        end
      end
      TX_PAYLOAD: begin
        if (last) begin
          if (pend_v_q) begin
            // promote pending; a same-edge request refills it
            cur_code_d  = pend_code_q;
            cur_word_d  = pend_word_q;
            state_d     = TX_HEADER;
            pend_v_d    = req_valid_i;
            if (req_valid_i) begin
              pend_code_d = req_code_i;
              pend_word_d = req_word;
            end
          end else if (req_valid_i) begin
            cur_code_d = req_code_i;
            cur_word_d = req_word;
            state_d    = TX_HEADER;
          end else begin
            state_d = TX_IDLE;
          end
        end else if (tx_ready_i) begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (req_valid_i && state_q != TX_IDLE && !last) begin
      if (!pend_v_q) begin
        pend_v_d    = 1'b1;
        pend_code_d = req_code_i;
        pend_word_d = req_word;
      end else begin
        drop_o = 1'b1;
      end
    end
  end

  assign tx_valid_o = (state_q != TX_IDLE);

  always_comb begin
    tx_data_o = '0;
    unique case (state_q)
      TX_HEADER:  tx_data_o = cur_code_q;
      TX_PAYLOAD: tx_data_o =
        cur_word_q[idx_q*INT_WIDTH +: INT_WIDTH];
      default:    tx_data_o = '0;
    endcase
  end

endmodule

// File: rtl/telemetry_command_interpreter.sv
// UART command decoder: motion strobes, error count and telemetry
// snapshot feeding the reply serializer. Ports: RX in, TELEM in, TX out.
module telemetry_command_interpreter
  import telemetry_interp_pkg::*;
#(
  parameter int N_WIDTH        = 17,
  parameter int INT_WIDTH      = 8,
  parameter int BYTES_PER_WORD = 3,
  parameter int N_WAYPOINTS    = 8,
  parameter int SEL_WIDTH      = 3
) (
  input  logic MESSAGE_INTERPRETER_CLOCK_50,
  input  logic MESSAGE_INTERPRETER_RESET_InHigh,
  input  logic MESSAGE_INTERPRETER_RXVALID_In,
  input  logic [INT_WIDTH-1:0]
               MESSAGE_INTERPRETER_RXDATA_InBus,
  input  logic [NUM_CHANNELS*N_WIDTH-1:0]
               MESSAGE_INTERPRETER_TELEM_InBus,
  input  logic MESSAGE_INTERPRETER_TXREADY_In,
  output logic MESSAGE_INTERPRETER_TXVALID_Out,
  output logic [INT_WIDTH-1:0]
               MESSAGE_INTERPRETER_TXDATA_OutBus,
  output logic [SEL_WIDTH-1:0]
               MESSAGE_INTERPRETER_WAYSELECT_OutBus,
  output logic MESSAGE_INTERPRETER_STOPSIGNAL_OutLow,
  output logic MESSAGE_INTERPRETER_BEGINSIGNAL_OutLow,
  output logic MESSAGE_INTERPRETER_NEWSIGNAL_OutLow,
  output logic [INT_WIDTH-1:0]
               MESSAGE_INTERPRETER_ERRCNT_OutBus
);

  localparam logic [7:0] WP_MAX = 8'(N_WAYPOINTS);

  logic clk, rst, rx_valid;
  logic [INT_WIDTH-1:0] rx_data;

  assign clk      = MESSAGE_INTERPRETER_CLOCK_50;
  assign rst      = MESSAGE_INTERPRETER_RESET_InHigh;
  assign rx_valid = MESSAGE_INTERPRETER_RXVALID_In;
  assign rx_data  = MESSAGE_INTERPRETER_RXDATA_InBus;

  logic [7:0] code;
  logic       hi_zero;
  chan_sel_t  csel;
  logic       is_wp, is_stop, is_begin, is_tel;
  logic       req_valid, is_err, drop;

  assign code    = rx_data[7:0];
  // wider bytes only decode when the upper bits are clear
  assign hi_zero = ((rx_data >> 8) == '0);
  assign csel    = code_to_channel(code);

  assign is_wp    = hi_zero && code >= CODE_WP_BASE &&
                    code <= WP_MAX;
  assign is_stop  = hi_zero && code == CODE_STOP;
  assign is_begin = hi_zero && code == CODE_BEGIN;
  assign is_tel   = hi_zero && csel.hit;

  assign req_valid = rx_valid && is_tel;
  assign is_err    = rx_valid &&
                     !(is_wp || is_stop || is_begin || is_tel);

  logic [N_WIDTH-1:0] chan [NUM_CHANNELS];
  logic [N_WIDTH-1:0] snap;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    assign chan[g] =
      MESSAGE_INTERPRETER_TELEM_InBus[g*N_WIDTH +: N_WIDTH];
  end

  always_comb begin
    snap = chan[csel.idx];
    if (is_narrow(csel.idx)) begin
      snap = N_WIDTH'(chan[csel.idx][INT_WIDTH-1:0]);
    end
  end

  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 stop_q, stop_d;
  logic                 begin_q, begin_d;
  logic                 new_q, new_d;
  logic [INT_WIDTH-1:0] errcnt_q, errcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= '0;
      stop_q   <= 1'b1;
      begin_q  <= 1'b1;
      new_q    <= 1'b1;
      errcnt_q <= '0;
    end else begin
      sel_q    <= sel_d;
      stop_q   <= stop_d;
      begin_q  <= begin_d;
      new_q    <= new_d;
      errcnt_q <= errcnt_d;
    end
  end

  always_comb begin
    sel_d   = sel_q;
    stop_d  = stop_q;
    begin_d = begin_q;
    new_d   = 1'b1;
    if (rx_valid) begin
      unique case (1'b1)
        is_wp: begin
          sel_d   = SEL_WIDTH'(code - CODE_WP_BASE);
          stop_d  = 1'b1;
          begin_d = 1'b1;
          new_d   = 1'b0;
        end
        is_stop: begin
          stop_d = 1'b0;
        end
        is_begin: begin
          sel_d   = '0;
          stop_d  = 1'b1;
          begin_d = 1'b0;
          new_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    errcnt_d = errcnt_q;
    if ((is_err || drop) && !(&errcnt_q)) begin
      errcnt_d = errcnt_q + 1'b1;
    end
  end

  tx_response_serializer #(
    .N_WIDTH        (N_WIDTH),
    .INT_WIDTH      (INT_WIDTH),
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_ser (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_code_i  (rx_data),
    .req_word_i  (snap),
    .tx_ready_i  (MESSAGE_INTERPRETER_TXREADY_In),
    .tx_valid_o  (MESSAGE_INTERPRETER_TXVALID_Out),
    .tx_data_o   (MESSAGE_INTERPRETER_TXDATA_OutBus),
    .drop_o      (drop)
  );

  assign MESSAGE_INTERPRETER_WAYSELECT_OutBus   = sel_q;
  assign MESSAGE_INTERPRETER_STOPSIGNAL_OutLow  = stop_q;
  assign MESSAGE_INTERPRETER_BEGINSIGNAL_OutLow = begin_q;
  assign MESSAGE_INTERPRETER_NEWSIGNAL_OutLow   = new_q;
  assign MESSAGE_INTERPRETER_ERRCNT_OutBus      = errcnt_q;

endmodule

// File: tb/tb_telemetry_command_interpreter.sv
// Randomized bench for telemetry_command_interpreter against a
// byte-stream reference model.
module tb_telemetry_command_interpreter;

  localparam int NW  = 17;
  localparam int BW  = 8;
  localparam int BPW = 3;
  localparam int NWP = 8;
  localparam int SW  = 3;
  localparam int RL  = 1 + BPW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            rx_valid = 1'b0;
  logic [BW-1:0]   rx_data = '0;
  logic [12*NW-1:0] telem = '0;
  logic            tx_ready = 1'b0;
  logic            tx_valid;
  logic [BW-1:0]   tx_data;
  logic [SW-1:0]   sel;
  logic            stop_n, begin_n, new_n;
  logic [BW-1:0]   errcnt;

  always #10 clk = ~clk;

  telemetry_command_interpreter #(
    .N_WIDTH(NW), .INT_WIDTH(BW), .BYTES_PER_WORD(BPW),
    .N_WAYPOINTS(NWP), .SEL_WIDTH(SW)
  ) dut (
    .MESSAGE_INTERPRETER_CLOCK_50          (clk),
    .MESSAGE_INTERPRETER_RESET_InHigh      (rst),
    .MESSAGE_INTERPRETER_RXVALID_In        (rx_valid),
    .MESSAGE_INTERPRETER_RXDATA_InBus      (rx_data),
    .MESSAGE_INTERPRETER_TELEM_InBus       (telem),
    .MESSAGE_INTERPRETER_TXREADY_In        (tx_ready),
    .MESSAGE_INTERPRETER_TXVALID_Out       (tx_valid),
    .MESSAGE_INTERPRETER_TXDATA_OutBus     (tx_data),
    .MESSAGE_INTERPRETER_WAYSELECT_OutBus  (sel),
    .MESSAGE_INTERPRETER_STOPSIGNAL_OutLow (stop_n),
    .MESSAGE_INTERPRETER_BEGINSIGNAL_OutLow(begin_n),
    .MESSAGE_INTERPRETER_NEWSIGNAL_OutLow  (new_n),
    .MESSAGE_INTERPRETER_ERRCNT_OutBus     (errcnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  logic [7:0] acc[$];
  int m_sel, m_err;
  bit m_stop, m_begin, m_new;

  logic [7:0] tel_codes [12] =
    '{20, 21, 22, 30, 31, 32, 33, 40, 41, 42, 43, 50};
  logic [7:0] bad_codes [6] = '{0, 11, 23, 34, 51, 255};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit tel_chan(input int c, output int ch);
    ch = 0;
    if (c >= 20 && c <= 22) ch = c - 20;
    else if (c >= 30 && c <= 33) ch = c - 27;
    else if (c >= 40 && c <= 43) ch = c - 33;
    else if (c == 50) ch = 11;
    else return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    acc.delete();
    m_sel = 0; m_err = 0;
    m_stop = 1; m_begin = 1; m_new = 1;
  endtask

  task automatic model_edge();
    int c, ch;
    logic [31:0] w;
    bit err;
    err = 0;
    if (mq.size() != 0 && tx_ready) void'(mq.pop_front());
    m_new = 1;
    if (rx_valid) begin
      c = int'(rx_data);
      if (c >= 1 && c <= NWP) begin
        m_sel = c - 1; m_stop = 1; m_begin = 1; m_new = 0;
      end else if (c == 9) begin
        m_stop = 0;
      end else if (c == 10) begin
        m_sel = 0; m_stop = 1; m_begin = 0; m_new = 0;
      end else if (tel_chan(c, ch)) begin
        w = 32'(telem[ch*NW +: NW]);
        if ((ch >= 3 && ch <= 6) || ch == 11) w = w & 32'hFF;
        // replies all have RL bytes: count outstanding replies
        if ((mq.size() + RL - 1) / RL < 2) begin
          mq.push_back(8'(c));
          for (int b = BPW - 1; b >= 0; b--)
            mq.push_back(8'(w >> (8 * b)));
        end else begin
          err = 1;
        end
      end else begin
        err = 1;
      end
    end
    if (err && m_err < 255) m_err++;
  endtask

  task automatic check_outs();
    chk("txvalid", tx_valid, 32'(mq.size() != 0));
    if (mq.size() != 0) chk("txdata", tx_data, mq[0]);
    chk("sel", sel, m_sel);
    chk("stop", stop_n, m_stop);
    chk("begin", begin_n, m_begin);
    chk("new", new_n, m_new);
    chk("errcnt", errcnt, m_err);
  endtask

  task automatic step();
    if (tx_valid && tx_ready) acc.push_back(tx_data);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic send(input logic [7:0] c);
    rx_valid = 1'b1;
    rx_data  = c;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_txvalid_now", tx_valid, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_txvalid", tx_valid, 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_sel", sel, 0);
    chk("rst_stop", stop_n, 1);
    chk("rst_begin", begin_n, 1);
    chk("rst_new", new_n, 1);
    chk("rst_errcnt", errcnt, 0);
    rst = 1'b0;
  endtask

  task automatic rand_telem();
    for (int ch = 0; ch < 12; ch++)
      telem[ch*NW +: NW] = NW'($urandom);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 6))
      0:       return 8'($urandom_range(1, 8));
      1:       return 8'($urandom_range(9, 10));
      2, 3, 4: return tel_codes[$urandom_range(0, 11)];
      5:       return 8'($urandom);
      default: return bad_codes[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    rand_telem();
    do_reset();

    // T1: waypoint 3
    send(8'd3);
    chk("t1_sel", sel, 2);
    chk("t1_new_low", new_n, 0);
    step();
    chk("t1_new_high", new_n, 1);

    // T2: stop then begin
    send(8'd9);
    chk("t2_stop", stop_n, 0);
    chk("t2_sel_hold", sel, 2);
    send(8'd10);
    chk("t2_sel", sel, 0);
    chk("t2_stop_rel", stop_n, 1);
    chk("t2_begin", begin_n, 0);
    chk("t2_new_low", new_n, 0);
    step();
    chk("t2_new_high", new_n, 1);

    // T3: x channel reply at full rate
    telem[0 +: NW] = 17'h1_2345;
    tx_ready = 1'b1;
    acc.delete();
    send(8'd20);
    repeat (5) step();
    chk("t3_len", acc.size(), 4);
    if (acc.size() == 4) begin
      chk("t3_b0", acc[0], 8'h14);
      chk("t3_b1", acc[1], 8'h01);
      chk("t3_b2", acc[2], 8'h23);
      chk("t3_b3", acc[3], 8'h45);
    end
    chk("t3_idle", tx_valid, 0);

    // T4: rpm1 with toggling ready; upper bits must be ignored
    telem[3*NW +: NW] = 17'h1_5EA7;
    acc.delete();
    send(8'd30);
    for (int i = 0; i < 8; i++) begin
      tx_ready = ~tx_ready;
      step();
    end
    tx_ready = 1'b1;
    repeat (4) step();
    chk("t4_len", acc.size(), 4);
    if (acc.size() == 4) begin
      chk("t4_b0", acc[0], 8'h1E);
      chk("t4_b1", acc[1], 8'h00);
      chk("t4_b2", acc[2], 8'h00);
      chk("t4_b3", acc[3], 8'hA7);
    end

    // T5: in service, pending, dropped
    do_reset();
    tx_ready = 1'b0;
    send(8'd40);
    send(8'd41);
    send(8'd42);
    step();
    chk("t5_errcnt", errcnt, 1);
    tx_ready = 1'b1;
    repeat (10) step();
    chk("t5_len", acc.size(), 8);
    if (acc.size() == 8) begin
      chk("t5_hdr0", acc[0], 8'h28);
      chk("t5_hdr1", acc[4], 8'h29);
    end

    // T6: reset mid-payload with a pending request
    tx_ready = 1'b0;
    send(8'd41);
    send(8'd42);
    tx_ready = 1'b1;
    step();
    step();
    do_reset();
    send(8'd22);
    repeat (6) step();
    chk("t6_len", acc.size(), 4);
    if (acc.size() == 4) chk("t6_hdr", acc[0], 8'h16);
    chk("t6_idle", tx_valid, 0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = pick();
      tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) rand_telem();
      step();
    end
    rx_valid = 1'b0;

    // error counter saturation
    tx_ready = 1'b1;
    repeat (300) send(8'd200);
    chk("sat_errcnt", errcnt, 255);
    send(8'd4);
    chk("sat_wp_sel", sel, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
